muldiv_seq: RTL and testbench

//   Iterative RV32M multiply/divide sequencer. Accepts one R-type op with

---
 rtl/muldiv_seq_if.sv | 25 ++
 rtl/muldiv_seq.sv | 195 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between decode and the iterative RV32M mul/div sequencer.
interface muldiv_seq_if #(parameter int XLEN = 32);
   logic            req_valid;
   logic            req_ready;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [4:0]      rd_in;
   logic            flush;
   logic            resp_valid;
   logic            resp_ready;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_out;
   logic            busy;

   modport master (
      output req_valid, funct3, op_a, op_b, rd_in, flush, resp_ready,
      input  req_ready, resp_valid, result, rd_out, busy
   );

   modport slave (
      input  req_valid, funct3, op_a, op_b, rd_in, flush, resp_ready,
      output req_ready, resp_valid, result, rd_out, busy
   );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: shift-add multiplier and restoring divider sharing one 64-bit register.
// Optional macro MULDIV_EARLY_OUT_EN: PREP skips CALC for zero operands, divide-by-zero and signed overflow.
module muldiv_seq #(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   muldiv_seq_if.slave  bus
);

   localparam int N  = XLEN / BITS_PER_CYCLE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PREP = 3'd1;
   localparam logic [2:0] S_CALC = 3'd2;
   localparam logic [2:0] S_FIX  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        f3_q, f3_d;
   logic [XLEN-1:0]   opa_q, opa_d;
   logic [XLEN-1:0]   opb_q, opb_d;
   logic [2*XLEN-1:0] prod_q, prod_d;
   logic              sa_q, sa_d;
   logic              sb_q, sb_d;
   logic              bz_q, bz_d;
   logic [4:0]        rd_q, rd_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              resp_valid_q, resp_valid_d;
`ifdef MULDIV_EARLY_OUT_EN
   logic              skip_q, skip_d;
   logic              ovf_q, ovf_d;
`endif

   logic req_ready_w;
   logic sgn_a, sgn_b;

   // Low half holds the multiplier / dividend-becoming-quotient, high half the
   // partial product / remainder; d is the multiplicand or divisor.
   function automatic logic [2*XLEN-1:0] step(input logic [2*XLEN-1:0] p,
                                              input logic [XLEN-1:0]   d,
                                              input logic              is_div);
      logic [XLEN:0] rs;
      logic [XLEN:0] sum;
      if (is_div) begin
         rs = {p[2*XLEN-1:XLEN], p[XLEN-1]};
         if (rs < {1'b0, d})
            step = {rs[XLEN-1:0], p[XLEN-2:0], 1'b0};
         else
            step = {rs[XLEN-1:0] - d, p[XLEN-2:0], 1'b1};
      end else begin
         sum  = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, d} : '0);
         step = {sum, p[XLEN-1:1]};
      end
   endfunction

   assign req_ready_w = (state_q == S_IDLE) && !bus.flush;

   // MULH/MULHSU/DIV/REM treat rs1 as signed; MULH/DIV/REM also rs2.
   assign sgn_a = (f3_q == 3'b001) || (f3_q == 3'b010) || (f3_q == 3'b100) || (f3_q == 3'b110);
   assign sgn_b = (f3_q == 3'b001) || (f3_q == 3'b100) || (f3_q == 3'b110);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      f3_d     = f3_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      prod_d   = prod_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      bz_d     = bz_q;
      rd_d     = rd_q;
      result_d = result_q;
`ifdef MULDIV_EARLY_OUT_EN
      skip_d   = skip_q;
      ovf_d    = ovf_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid && req_ready_w) begin
               f3_d    = bus.funct3;
               opa_d   = bus.op_a;
               opb_d   = bus.op_b;
               rd_d    = bus.rd_in;
               state_d = S_PREP;
            end
         end
         S_PREP: begin
            sa_d   = sgn_a && opa_q[XLEN-1];
            sb_d   = sgn_b && opb_q[XLEN-1];
            prod_d = {{XLEN{1'b0}}, (sa_d ? -opa_q : opa_q)};
            opb_d  = sb_d ? -opb_q : opb_q;
            bz_d   = (opb_q == '0);
            cnt_d  = CW'(N - 1);
            state_d = S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
            ovf_d  = f3_q[2] && sgn_b && (opa_q == {1'b1, {(XLEN-1){1'b0}}}) && (opb_q == '1);
            skip_d = f3_q[2] ? (bz_d || ovf_d) : ((opa_q == '0) || (opb_q == '0));
            if (skip_d) state_d = S_FIX;
`endif
         end
         S_CALC: begin
            for (int k = 0; k < BITS_PER_CYCLE; k++)
               prod_d = step(prod_d, opb_q, f3_q[2]);
            if (cnt_q == '0) state_d = S_FIX;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_FIX: begin
            if (!f3_q[2]) begin
               if (f3_q[1:0] == 2'b00)
                  result_d = prod_q[XLEN-1:0];
               else if (sa_q ^ sb_q)
                  result_d = XLEN'((~prod_q + 1'b1) >> XLEN);
               else
                  result_d = prod_q[2*XLEN-1:XLEN];
            end else if (!f3_q[1]) begin
               // A zero divisor yields all-ones regardless of the dividend sign.
               if (bz_q)             result_d = '1;
               else if (sa_q ^ sb_q) result_d = -prod_q[XLEN-1:0];
               else                  result_d = prod_q[XLEN-1:0];
            end else begin
               result_d = sa_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
            end
`ifdef MULDIV_EARLY_OUT_EN
            // Skipped ops: prod_q still holds |rs1| in the low half.
            if (skip_q) begin
               if (!f3_q[2])
                  result_d = '0;
               else if (bz_q)
                  result_d = f3_q[1] ? (sa_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0]) : '1;
               else
                  result_d = f3_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            end
`endif
            state_d = S_DONE;
         end
         S_DONE: begin
            if (bus.resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (bus.flush && (state_q != S_IDLE)) state_d = S_IDLE;
      resp_valid_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         f3_q         <= '0;
         opa_q        <= '0;
         opb_q        <= '0;
         prod_q       <= '0;
         sa_q         <= 1'b0;
         sb_q         <= 1'b0;
         bz_q         <= 1'b0;
         rd_q         <= '0;
         result_q     <= '0;
         resp_valid_q <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
         skip_q       <= 1'b0;
         ovf_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         f3_q         <= f3_d;
         opa_q        <= opa_d;
         opb_q        <= opb_d;
         prod_q       <= prod_d;
         sa_q         <= sa_d;
         sb_q         <= sb_d;
         bz_q         <= bz_d;
         rd_q         <= rd_d;
         result_q     <= result_d;
         resp_valid_q <= resp_valid_d;
`ifdef MULDIV_EARLY_OUT_EN
         skip_q       <= skip_d;
         ovf_q        <= ovf_d;
`endif
      end
   end

   assign bus.req_ready  = req_ready_w;
   assign bus.resp_valid = resp_valid_q;
   assign bus.result     = result_q;
   assign bus.rd_out     = rd_q;
   assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: reference results from 64-bit arithmetic, latency and handshake checks.
module tb_muldiv_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   muldiv_seq_if bus ();

   muldiv_seq #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          lat;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa64, sb64, sp;
      logic        [63:0] ua64, ub64, up;
      logic               ovf;
      sa64 = {{32{a[31]}}, a};
      sb64 = {{32{b[31]}}, b};
      ua64 = {32'b0, a};
      ub64 = {32'b0, b};
      ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'd0: begin up = ua64 * ub64; return up[31:0]; end
         3'd1: begin sp = sa64 * sb64; return sp[63:32]; end
         3'd2: begin sp = sa64 * $signed(ub64); return sp[63:32]; end
         3'd3: begin up = ua64 * ub64; return up[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
      if (f3[2] ? ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
                : ((a == 0) || (b == 0)))
         return 2;
`endif
      return 34;
   endfunction

   // Drive one request, wait for its accept edge, then scramble the inputs.
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input string name, input bit push);
      int w;
      exp_t e;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.funct3    = f3;
      bus.op_a      = a;
      bus.op_b      = b;
      bus.rd_in     = rd;
      w = 0;
      while (!bus.req_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (w == 100) chk({name, "_accept"}, 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      if (push) begin
         e.res  = ref_op(f3, a, b);
         e.rd   = rd;
         e.lat  = ref_lat(f3, a, b);
         e.name = name;
         sb.push_back(e);
      end
      #1;
      bus.req_valid = 1'b0;
      bus.funct3    = 3'($urandom);
      bus.op_a      = $urandom;
      bus.op_b      = $urandom;
      bus.rd_in     = 5'($urandom);
   endtask

   task automatic collect(input int hold);
      int   lat;
      exp_t e;
      lat = 0;
      while (!bus.resp_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (sb.size() == 0) begin
         chk("sb_empty", 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         chk({e.name, "_lat"}, 32'(lat), 32'(e.lat));
         chk({e.name, "_res"}, bus.result, e.res);
         chk({e.name, "_rd"}, 32'(bus.rd_out), 32'(e.rd));
         for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({e.name, "_hold_vld"}, 32'(bus.resp_valid), 32'd1);
            chk({e.name, "_hold_res"}, bus.result, e.res);
            chk({e.name, "_hold_rd"}, 32'(bus.rd_out), 32'(e.rd));
            chk({e.name, "_hold_rdy"}, 32'(bus.req_ready), 32'd0);
         end
         @(negedge clk);
         bus.resp_ready = 1'b1;
         @(posedge clk);
         #1;
         bus.resp_ready = 1'b0;
         chk({e.name, "_vld_clr"}, 32'(bus.resp_valid), 32'd0);
         chk({e.name, "_idle"}, 32'(bus.busy), 32'd0);
         chk({e.name, "_rdy_back"}, 32'(bus.req_ready), 32'd1);
      end
   endtask

   task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input string name);
      issue(f3, a, b, rd, name, 1'b1);
      collect(0);
   endtask

   initial begin
      int seen;
      bus.req_valid  = 1'b0;
      bus.funct3     = '0;
      bus.op_a       = '0;
      bus.op_b       = '0;
      bus.rd_in      = '0;
      bus.flush      = 1'b0;
      bus.resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_vld",  32'(bus.resp_valid), 32'd0);
      chk("rst_res",  bus.result, 32'd0);
      chk("rst_rd",   32'(bus.rd_out), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_rdy",  32'(bus.req_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors, first one held in DONE for 10 cycles.
      issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, "mul_7x-3", 1'b1);
      collect(10);
      run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, "mulhu_ff");
      run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, "mulh_ff");
      run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, "mulhsu_ff");
      run(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, "div_-7_2");
      run(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, "rem_-7_2");
      run(3'd5, 32'd100, 32'd7, 5'd7, "divu_100_7");
      run(3'd7, 32'd100, 32'd7, 5'd8, "remu_100_7");
      run(3'd4, 32'd5, 32'd0, 5'd9, "div_5_0");
      run(3'd7, 32'd5, 32'd0, 5'd10, "remu_5_0");
      run(3'd4, 32'hFFFF_FFFB, 32'd0, 5'd11, "div_-5_0");
      run(3'd6, 32'hFFFF_FFFB, 32'd0, 5'd12, "rem_-5_0");
      run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, "div_ovf");
      run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, "rem_ovf");
      run(3'd0, 32'd0, 32'h1234_5678, 5'd15, "mul_zero");
      run(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd16, "mulh_min");

      // Random ops through the scoreboard.
      for (int i = 0; i < 12; i++)
         run(3'($urandom), $urandom, (i % 4 == 0) ? 32'($urandom_range(0, 15)) : $urandom,
             5'($urandom), $sformatf("rnd%0d", i));

      // Flush mid-CALC: op is dropped.
      issue(3'd0, 32'd123, 32'd456, 5'd20, "flushed", 1'b0);
      repeat (11) @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      chk("flush_busy", 32'(bus.busy), 32'd0);
      chk("flush_vld",  32'(bus.resp_valid), 32'd0);
      chk("flush_rdy",  32'(bus.req_ready), 32'd0);
      @(negedge clk);
      bus.flush = 1'b0;
      #1;
      chk("flush_rdy_back", 32'(bus.req_ready), 32'd1);

      // Reset mid-CALC of a new op: back to reset values immediately.
      issue(3'd4, 32'd1000, 32'd3, 5'd21, "reset_lost", 1'b0);
      repeat (6) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_vld",  32'(bus.resp_valid), 32'd0);
      chk("mid_rst_res",  bus.result, 32'd0);
      chk("mid_rst_rd",   32'(bus.rd_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_rdy", 32'(bus.req_ready), 32'd1);
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.resp_valid) seen++;
      end
      chk("no_resp_after_kill", 32'(seen), 32'd0);

      run(3'd6, 32'hFFFF_FF9C, 32'd7, 5'd22, "rem_after_kill");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
